door_lock_ctrl: RTL and testbench

- Downstream stage of the access-code FSM; consumes its `open_access_door` request and drives the physical lock solenoid.
- Holds the door unlocked for a bounded window and tracks the door-closed sensor.
- Raises an alarm on forced entry or a door held open too long.
- Reports state for debug/monitoring.

---
 rtl/door_lock_ctrl.sv | 111 +++++++++++
 tb/tb_door_lock_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/door_lock_ctrl.sv
// Door lock controller: drives the solenoid after an access grant,
// watches the door sensor and raises an alarm on forced or prolonged entry.
module door_lock_ctrl #(
  parameter int UNLOCK_CYCLES = 10,
  parameter int AJAR_LIMIT    = 20,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       open_access_door,
  input  logic       door_closed,
  input  logic       alarm_clr,
  output logic       unlock,
  output logic       alarm,
  output logic       busy,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    LOCKED   = 2'b00,
    UNLOCKED = 2'b01,
    OPEN     = 2'b10,
    ALARM    = 2'b11
  } state_t;

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (UNLOCK_CYCLES < 1 || UNLOCK_CYCLES > CNT_MAX) begin : g_bad_unl
    $error("UNLOCK_CYCLES out of range");
  end
  if (AJAR_LIMIT < 1 || AJAR_LIMIT > CNT_MAX) begin : g_bad_ajar
    $error("AJAR_LIMIT out of range");
  end

  localparam logic [CNT_W-1:0] UNL_LD  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] AJAR_LD = CNT_W'(AJAR_LIMIT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             req_d;
  logic             req_edge;

  assign req_edge = open_access_door & ~req_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      LOCKED: begin
        // forced entry outranks a simultaneous grant
        if (!door_closed) begin
          state_nxt = ALARM;
        end else if (req_edge) begin
          state_nxt = UNLOCKED;
          cnt_nxt   = UNL_LD;
        end
      end
      UNLOCKED: begin
        if (!door_closed) begin
          state_nxt = OPEN;
          cnt_nxt   = AJAR_LD;
        end else if (req_edge) begin
          cnt_nxt = UNL_LD;
        end else if (cnt == '0) begin
          state_nxt = LOCKED;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      OPEN: begin
        if (door_closed) begin
          state_nxt = LOCKED;
        end else if (cnt == '0) begin
          state_nxt = ALARM;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      ALARM: begin
        if (alarm_clr && door_closed) begin
          state_nxt = LOCKED;
        end
      end
      default: state_nxt = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOCKED;
      cnt       <= '0;
      req_d     <= 1'b0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      busy      <= 1'b0;
      state_out <= 2'b00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_d     <= open_access_door;
      unlock    <= (state_nxt == UNLOCKED);
      alarm     <= (state_nxt == ALARM);
      busy      <= (state_nxt != LOCKED);
      state_out <= state_nxt;
    end
  end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Bench for door_lock_ctrl: directed scenarios with literal expectations
// plus random traffic checked every cycle against a behavioural model.
module tb_door_lock_ctrl;

  localparam int UNL  = 10;
  localparam int AJAR = 20;

  localparam int M_LOCKED = 0;
  localparam int M_UNLOCK = 1;
  localparam int M_OPEN   = 2;
  localparam int M_ALARM  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       open_access_door = 1'b0;
  logic       door_closed = 1'b1;
  logic       alarm_clr = 1'b0;
  logic       unlock;
  logic       alarm;
  logic       busy;
  logic [1:0] state_out;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  int m_mode = M_LOCKED;
  int m_left = 0;
  bit m_prev = 0;

  int t_unl = 0;
  int t_open = 0;
  int t_alarm = 0;

  door_lock_ctrl #(
    .UNLOCK_CYCLES(UNL),
    .AJAR_LIMIT(AJAR),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .open_access_door(open_access_door),
    .door_closed(door_closed),
    .alarm_clr(alarm_clr),
    .unlock(unlock),
    .alarm(alarm),
    .busy(busy),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // m_left counts cycles still to spend in the current timed window
  always @(posedge clk) begin
    bit grant_rise;
    grant_rise = open_access_door && !m_prev;
    if (rst) begin
      m_mode = M_LOCKED;
      m_prev = 0;
    end else begin
      m_prev = open_access_door;
      case (m_mode)
        M_LOCKED:
          if (!door_closed) m_mode = M_ALARM;
          else if (grant_rise) begin
            m_mode = M_UNLOCK;
            m_left = UNL;
          end
        M_UNLOCK:
          if (!door_closed) begin
            m_mode = M_OPEN;
            m_left = AJAR;
          end else if (grant_rise) m_left = UNL;
          else begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_LOCKED;
          end
        M_OPEN:
          if (door_closed) m_mode = M_LOCKED;
          else begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_ALARM;
          end
        default:
          if (alarm_clr && door_closed) m_mode = M_LOCKED;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_v;
    logic [4:0] got_v;
    if (chk_en) begin
      exp_v = {m_mode == M_UNLOCK, m_mode == M_ALARM,
               m_mode != M_LOCKED, 2'(m_mode)};
      got_v = {unlock, alarm, busy, state_out};
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL model t=%0t got {unl,alm,busy,st}=%b expected %b",
                 $time, got_v, exp_v);
      end
      if (unlock) t_unl++;
      if (state_out == 2'b10) t_open++;
      if (alarm) t_alarm++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    open_access_door = 1'b0;
    door_closed = 1'b1;
    alarm_clr = 1'b0;
    tick(2);
    rst = 1'b0;
    chk_en = 1;
  endtask

  task automatic pulse();
    open_access_door = 1'b1;
    tick(1);
    open_access_door = 1'b0;
  endtask

  initial begin
    int s_unl;
    int s_open;
    int s_alarm;

    do_reset();
    check("reset_state", int'(state_out), 0);
    check("reset_busy", int'(busy), 0);

    // 1: plain unlock window
    s_unl = t_unl; s_alarm = t_alarm;
    pulse();
    check("t1_unlock_now", int'(unlock), 1);
    tick(20);
    check("t1_unl_cycles", t_unl - s_unl, 10);
    check("t1_no_alarm", t_alarm - s_alarm, 0);
    check("t1_state", int'(state_out), 0);
    check("t1_busy", int'(busy), 0);

    // 2: door opened briefly then closed
    s_open = t_open; s_alarm = t_alarm;
    pulse();
    tick(2);
    door_closed = 1'b0;
    tick(1);
    check("t2_open_state", int'(state_out), 2);
    check("t2_open_unlock", int'(unlock), 0);
    tick(4);
    door_closed = 1'b1;
    tick(1);
    check("t2_relock", int'(state_out), 0);
    tick(3);
    check("t2_open_cycles", t_open - s_open, 5);
    check("t2_no_alarm", t_alarm - s_alarm, 0);

    // 3: door held open until alarm
    s_open = t_open;
    pulse();
    tick(2);
    door_closed = 1'b0;
    tick(30);
    check("t3_open_cycles", t_open - s_open, 20);
    check("t3_alarm", int'(alarm), 1);
    check("t3_state", int'(state_out), 3);
    alarm_clr = 1'b1;
    tick(3);
    check("t3_clr_door_open", int'(state_out), 3);
    door_closed = 1'b1;
    tick(1);
    check("t3_cleared", int'(state_out), 0);
    alarm_clr = 1'b0;
    tick(2);

    // 4: forced entry beats a simultaneous grant
    s_unl = t_unl;
    door_closed = 1'b0;
    open_access_door = 1'b1;
    tick(1);
    check("t4_state", int'(state_out), 3);
    check("t4_alarm", int'(alarm), 1);
    open_access_door = 1'b0;
    tick(2);
    check("t4_no_unlock", t_unl - s_unl, 0);
    door_closed = 1'b1;
    alarm_clr = 1'b1;
    tick(1);
    alarm_clr = 1'b0;
    tick(1);

    // 5: held grant fires once; re-raise restarts window
    s_unl = t_unl;
    open_access_door = 1'b1;
    tick(30);
    check("t5_held_once", t_unl - s_unl, 10);
    open_access_door = 1'b0;
    tick(1);
    s_unl = t_unl;
    open_access_door = 1'b1;
    tick(5);
    open_access_door = 1'b0;
    tick(1);
    open_access_door = 1'b1;
    tick(30);
    check("t5_restart", t_unl - s_unl, 16);
    open_access_door = 1'b0;
    tick(2);

    // 6: reset from UNLOCKED, OPEN and ALARM
    for (int k = 0; k < 3; k++) begin
      pulse();
      tick(1);
      if (k > 0) door_closed = 1'b0;
      if (k == 2) tick(AJAR + 2);
      else tick(2);
      check("t6_pre_state", int'(state_out), k + 1);
      open_access_door = 1'b1;
      door_closed = 1'b1;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t6_rst_state", int'(state_out), 0);
      check("t6_rst_outs", int'({unlock, alarm, busy}), 0);
      tick(1);
      check("t6_regrant", int'(unlock), 1);
      open_access_door = 1'b0;
      tick(12);
    end

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) open_access_door = ~open_access_door;
      if ($urandom_range(0, 19) == 0) door_closed = ~door_closed;
      alarm_clr = ($urandom_range(0, 4) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
